// File: rtl/tx_serial_fifo.sv
// Avalon-MM serial transmitter: write FIFO, run-time baud divisor, framing FSM, status/irq.
// Optional parity support is compiled in with `define TX_SERIAL_FIFO_PARITY_EN.
module tx_serial_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int DIV_RESET  = 433
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        tx_serial_data,
  output logic [7:0]  led_readdata
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [15:0] DIV_INIT  = 16'(DIV_RESET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_SERIAL_FIFO_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [DATA_W-1:0] fifo_rdata;
  logic              ovf_q, en_q, irq_en_q;
  logic [15:0]       divisor_q, div_lat_q, cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_d, load;
  logic              wr_data, wr_status, wr_div, wr_ctrl;
  logic              full, empty, busy, push, can_load, bit_end;
  logic [8:0]        level_ext;
  logic [31:0]       rd_mux;
  logic              unused_bits;
`ifdef TX_SERIAL_FIFO_PARITY_EN
  logic              par_en_cfg_q, odd_cfg_q, par_en_q, par_bit_q;
`endif

  assign wr_data     = avs_write && (avs_address == 2'd0);
  assign wr_status   = avs_write && (avs_address == 2'd1);
  assign wr_div      = avs_write && (avs_address == 2'd2);
  assign wr_ctrl     = avs_write && (avs_address == 2'd3);
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign busy        = (state_q != S_IDLE);
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push        = wr_data && (!full || load);
  assign can_load    = en_q && !empty;
  assign bit_end     = (cnt_q == 16'd0);
  assign fifo_rdata  = mem[rd_ptr_q];
  assign level_ext   = 9'(count_q);
  assign unused_bits = ^{avs_writedata[31:16], level_ext[8]};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    tx_d    = tx_serial_data;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = bit_end ? div_lat_q : cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        tx_d  = 1'b1;
        if (can_load) begin
          load    = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_DATA) begin
`ifdef TX_SERIAL_FIFO_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
            idx_d = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef TX_SERIAL_FIFO_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            // Chain straight into the next start bit when more data is queued.
            if (can_load) begin
              load    = 1'b1;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      cnt_d   = divisor_q;
      shift_d = fifo_rdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd1: begin
        rd_mux[0]    = full;
        rd_mux[1]    = empty;
        rd_mux[2]    = busy;
        rd_mux[3]    = ovf_q;
        rd_mux[15:8] = level_ext[7:0];
      end
      2'd2: rd_mux[15:0] = divisor_q;
      2'd3: begin
        rd_mux[0] = en_q;
        rd_mux[1] = irq_en_q;
`ifdef TX_SERIAL_FIFO_PARITY_EN
        rd_mux[2] = par_en_cfg_q;
        rd_mux[3] = odd_cfg_q;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= S_IDLE;
      tx_serial_data <= 1'b1;
      cnt_q          <= '0;
      idx_q          <= '0;
      div_lat_q      <= DIV_INIT;
      led_readdata   <= '0;
      irq            <= 1'b0;
      avs_readdata   <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      divisor_q      <= DIV_INIT;
      en_q           <= 1'b0;
      irq_en_q       <= 1'b0;
`ifdef TX_SERIAL_FIFO_PARITY_EN
      par_en_cfg_q   <= 1'b0;
      odd_cfg_q      <= 1'b0;
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tx_serial_data <= tx_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      irq            <= irq_en_q & empty & ~busy;
      avs_readdata   <= avs_read ? rd_mux : '0;
      if (load) begin
        div_lat_q    <= divisor_q;
        rd_ptr_q     <= rd_ptr_q + AW'(1);
        led_readdata <= 8'(fifo_rdata);
`ifdef TX_SERIAL_FIFO_PARITY_EN
        par_en_q     <= par_en_cfg_q;
        par_bit_q    <= (^fifo_rdata) ^ odd_cfg_q;
`endif
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      case ({push, load})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (wr_data && full && !load) ovf_q <= 1'b1;
      else if (wr_status && avs_writedata[3]) ovf_q <= 1'b0;
      if (wr_div) divisor_q <= (avs_writedata[15:0] == 16'd0) ? 16'd1 : avs_writedata[15:0];
      if (wr_ctrl) begin
        en_q     <= avs_writedata[0];
        irq_en_q <= avs_writedata[1];
`ifdef TX_SERIAL_FIFO_PARITY_EN
        par_en_cfg_q <= avs_writedata[2];
        odd_cfg_q    <= avs_writedata[3];
`endif
      end
    end
  end

  // Storage and shifter carry data only; they need no reset.
  always_ff @(posedge clk_clk) begin
    shift_q <= shift_d;
    if (push) mem[wr_ptr_q] <= avs_writedata[DATA_W-1:0];
  end

endmodule

// File: tb/tb_tx_serial_fifo.sv
// Scoreboard bench for tx_serial_fifo: register reads and serial frames are checked by monitors.
`timescale 1ns/1ps
module tb_tx_serial_fifo;

  logic        clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        tx_serial_data;
  logic [7:0]  led_readdata;

  tx_serial_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1), .DIV_RESET(433)) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .tx_serial_data(tx_serial_data),
    .led_readdata  (led_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int len;
    int par;
    int gap;
    int start_c;
    int abort;
  } frame_t;

  frame_t      exp_fr[$];
  logic [31:0] exp_rd_val[$];
  logic [31:0] exp_rd_mask[$];
  string       exp_rd_name[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          idle_cnt = 0;
  bit          in_frame = 1'b0;
  int          last_wcyc = 0;
  logic        rd_vld = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= avs_read;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic frame_t mkf(input int data, input int len, input int par, input int gap,
                                 input int start_c, input int abort);
    frame_t f;
    f.data = data; f.len = len; f.par = par; f.gap = gap; f.start_c = start_c; f.abort = abort;
    return f;
  endfunction

  // Register read monitor
  initial begin : rd_mon
    logic [31:0] m;
    forever begin
      @(negedge clk);
      if (rd_vld) begin
        if (exp_rd_val.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got 0x%0h, expected no read data", avs_readdata);
        end else begin
          m = exp_rd_mask.pop_front();
          check(exp_rd_name.pop_front(), avs_readdata & m, exp_rd_val.pop_front());
        end
      end
    end
  end

  // Serial line monitor: compares each frame cycle by cycle against the expected waveform
  initial begin : frame_mon
    frame_t fr;
    int n, bi, eb, ok, got, aborted, k;
    forever begin
      @(negedge clk);
      if (!reset_reset_n) begin
        idle_cnt = 0;
        in_frame = 1'b0;
      end else if (tx_serial_data === 1'b1) begin
        idle_cnt++;
      end else if (exp_fr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame: line low at cycle %0d, expected idle high", cyc);
        k = 0; idle_cnt = 0;
        while (idle_cnt < 64 && k < 20000 && reset_reset_n) begin
          @(negedge clk);
          k++;
          if (tx_serial_data === 1'b1) idle_cnt++; else idle_cnt = 0;
        end
      end else begin
        in_frame = 1'b1;
        fr = exp_fr.pop_front();
        if (fr.start_c >= 0) check("start_latency", cyc, fr.start_c);
        if (fr.gap >= 0) check("frame_gap", idle_cnt, fr.gap);
        n = (1 + 8 + ((fr.par >= 0) ? 1 : 0) + 1) * fr.len;
        ok = 1; got = 0; aborted = 0;
        for (int i = 0; i < n; i++) begin
          if (i > 0) @(negedge clk);
          if (!reset_reset_n) begin aborted = 1; break; end
          bi = i / fr.len;
          if (bi == 0) eb = 0;
          else if (bi <= 8) eb = (fr.data >> (bi - 1)) & 1;
          else if (fr.par >= 0 && bi == 9) eb = fr.par;
          else eb = 1;
          if (tx_serial_data !== eb[0]) ok = 0;
          if (bi >= 1 && bi <= 8 && (i % fr.len) == fr.len / 2 && tx_serial_data === 1'b1)
            got = got | (1 << (bi - 1));
        end
        check("frame_abort", aborted, fr.abort);
        if (!aborted) begin
          check("frame_data", got, fr.data);
          check("frame_wave", ok, 1);
        end
        idle_cnt = 0;
        in_frame = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; last_wcyc = cyc;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m,
                          input string name);
    exp_rd_val.push_back(e & m); exp_rd_mask.push_back(m); exp_rd_name.push_back(name);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int c = 0;
    while ((exp_fr.size() != 0 || in_frame) && c < maxc) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 32'(c < maxc), 32'd1);
    if (c >= maxc) exp_fr.delete();
    cycles(2);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  w0;
    logic hi_ok;
    // Reset values
    cycles(3);
    check("rst_tx", tx_serial_data, 1);
    check("rst_led", led_readdata, 0);
    check("rst_irq", irq, 0);
    check("rst_readdata", avs_readdata, 0);
    reset_reset_n = 1'b1;
    cycles(2);
    bus_read(2'd1, 32'h0000_0002, 32'hFFFF, "init_status");
    bus_read(2'd2, 32'd433, 32'hFFFF_FFFF, "init_divisor");
    bus_read(2'd3, 32'h0, 32'hFFFF_FFFF, "init_control");

    // Single frame 0xA5 at 4 clocks per bit
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'h3);
    cycles(2);
    check("irq_idle_empty", irq, 1);
    bus_write(2'd0, 32'hA5);
    exp_fr.push_back(mkf(32'hA5, 4, -1, -1, last_wcyc + 2, 0));
    cycles(5);
    check("irq_busy", irq, 0);
    wait_idle(200, "wait_a5");
    check("irq_after_stop", irq, 1);
    check("led_a5", led_readdata, 8'hA5);

    // Fill FIFO with transmitter disabled; overflow; full push+pop
    bus_write(2'd3, 32'h2);
    for (int i = 0; i < 17; i++) bus_write(2'd0, 32'h10 + i);
    bus_read(2'd1, 32'h0000_1009, 32'hFFFF, "full_status");
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, 32'h0000_1001, 32'hFFFF, "ovf_cleared");
    for (int i = 0; i < 16; i++) exp_fr.push_back(mkf(32'h10 + i, 4, -1, (i == 0) ? -1 : 0, -1, 0));
    exp_fr.push_back(mkf(32'h55, 4, -1, 0, -1, 0));
    bus_write(2'd3, 32'h3);
    bus_write(2'd0, 32'h55);
    bus_read(2'd1, 32'h0000_1005, 32'hFFFF, "push_pop_full");
    wait_idle(2000, "wait_burst");
    check("led_last", led_readdata, 8'h55);

    // Divisor change mid-frame applies to the next frame
    bus_write(2'd0, 32'h3C);
    exp_fr.push_back(mkf(32'h3C, 4, -1, -1, last_wcyc + 2, 0));
    bus_write(2'd0, 32'hC3);
    exp_fr.push_back(mkf(32'hC3, 8, -1, 0, -1, 0));
    bus_write(2'd2, 32'd7);
    wait_idle(400, "wait_div");
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, 32'd1, 32'hFFFF_FFFF, "div_zero");
    bus_write(2'd2, 32'd3);

    // Clear EN mid-frame of a 3-byte burst
    bus_write(2'd0, 32'h11);
    w0 = last_wcyc;
    exp_fr.push_back(mkf(32'h11, 4, -1, -1, w0 + 2, 0));
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    cycles(12);
    bus_write(2'd3, 32'h2);
    wait_idle(200, "wait_en_clear");
    hi_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycles(1);
      hi_ok = hi_ok & tx_serial_data;
    end
    check("line_held_high", hi_ok, 1);
    bus_read(2'd1, 32'h0000_0200, 32'hFFFF, "held_status");
    check("irq_held", irq, 0);
    exp_fr.push_back(mkf(32'h22, 4, -1, -1, -1, 0));
    exp_fr.push_back(mkf(32'h33, 4, -1, 0, -1, 0));
    bus_write(2'd3, 32'h3);
    wait_idle(300, "wait_resume");
    check("irq_resume_done", irq, 1);

    // Reset asserted in the middle of a frame
    bus_write(2'd0, 32'h00);
    exp_fr.push_back(mkf(32'h00, 4, -1, -1, last_wcyc + 2, 1));
    bus_write(2'd0, 32'h44);
    cycles(12);
    check("line_low_mid_frame", tx_serial_data, 0);
    reset_reset_n = 1'b0;
    #1;
    check("rst_line_high", tx_serial_data, 1);
    cycles(2);
    check("rst2_led", led_readdata, 0);
    check("rst2_irq", irq, 0);
    reset_reset_n = 1'b1;
    cycles(2);
    bus_read(2'd1, 32'h0000_0002, 32'hFFFF, "rst2_status");
    bus_read(2'd2, 32'd433, 32'hFFFF_FFFF, "rst2_divisor");
    bus_read(2'd3, 32'h0, 32'hFFFF_FFFF, "rst2_control");

`ifdef TX_SERIAL_FIFO_PARITY_EN
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'h5);
    bus_write(2'd0, 32'h07);
    exp_fr.push_back(mkf(32'h07, 4, 1, -1, last_wcyc + 2, 0));
    wait_idle(200, "wait_par_even");
    bus_write(2'd3, 32'hD);
    bus_read(2'd3, 32'hD, 32'hFFFF_FFFF, "ctrl_par");
    bus_write(2'd0, 32'h07);
    exp_fr.push_back(mkf(32'h07, 4, 0, -1, last_wcyc + 2, 0));
    wait_idle(200, "wait_par_odd");
`else
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, 32'h3, 32'hFFFF_FFFF, "ctrl_nopar");
`endif
    bus_write(2'd3, 32'h0);
    cycles(5);
    check("rd_queue_drained", exp_rd_val.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
